// File: rtl/spi_pkg.sv
// Shared definitions for the system-clock SPI slave: word width,
// the idle transmit pattern and the controller state encoding.
package spi_pkg;

   localparam int SPI_WORD_W = 8;

   localparam logic [SPI_WORD_W-1:0] DEFAULT_TX_WORD = 8'hA5;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a
// registered rise/fall detector. The edge pulses come straight from
// flops, so the controller only ever sees clean single-cycle strobes.
module spi_sync_edge #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              level_prev;

   assign level = sync_q[STAGES-1];

   // Shift the raw pin through the synchronizer and register edge pulses
   // by comparing the synchronized level against its one-cycle-old copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= {STAGES{RESET_LEVEL}};
         level_prev <= RESET_LEVEL;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         sync_q     <= {sync_q[STAGES-2:0], async_in};
         level_prev <= sync_q[STAGES-1];
         rise       <= sync_q[STAGES-1] & ~level_prev;
         fall       <= ~sync_q[STAGES-1] & level_prev;
      end
   end

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first, running entirely on the system clock.
// sclk, chip_select and mosi are oversampled; received words come out
// with a one-cycle strobe and transmit words go in through a one-word
// valid/ready buffer. Several words may follow each other under one
// chip-select assertion.
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = SPI_WORD_W,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DEFAULT_TX_WORD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  chip_select,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  busy
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   // Synchronized pin views and edge strobes
   logic sclk_rise;
   logic sclk_fall;
   logic sclk_level_unused;
   logic cs_assert;
   logic cs_deassert;
   logic cs_level_unused;
   logic mosi_level;
   logic mosi_rise_unused;
   logic mosi_fall_unused;

   // Controller state and datapath registers
   spi_state_e            state;
   spi_state_e            state_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  word_done;
   logic                  rx_pending;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  buf_full;

   // Decoded actions for this cycle
   logic                  load_req;
   logic                  shift_rx;
   logic                  shift_tx;
   logic                  tx_write;
   logic [DATA_WIDTH-1:0] load_word;

   spi_sync_edge #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (1'b0)
   ) u_sync_sclk (
      .clk      (clk),
      .reset    (reset),
      .async_in (sclk),
      .level    (sclk_level_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   // Chip select idles high, so its synchronizer comes out of reset
   // already deselected and cannot fake an assertion edge.
   spi_sync_edge #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (1'b1)
   ) u_sync_cs (
      .clk      (clk),
      .reset    (reset),
      .async_in (chip_select),
      .level    (cs_level_unused),
      .rise     (cs_deassert),
      .fall     (cs_assert)
   );

   spi_sync_edge #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (1'b0)
   ) u_sync_mosi (
      .clk      (clk),
      .reset    (reset),
      .async_in (mosi),
      .level    (mosi_level),
      .rise     (mosi_rise_unused),
      .fall     (mosi_fall_unused)
   );

   assign tx_ready = ~buf_full;
   assign tx_write = tx_valid & tx_ready;

   // A word load prefers the buffered word; a write landing in the same
   // cycle as the load is passed straight through; otherwise idle pattern.
   assign load_word = buf_full ? buf_data :
                      tx_write ? tx_data  : DEFAULT_TX;

   assign busy    = (state == ST_ACTIVE);
   assign miso_oe = busy;
   assign miso    = busy & tx_shift[DATA_WIDTH-1];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cycle actions; a chip-select release wins over
   // any sclk edge seen in the same cycle.
   always_comb begin
      state_next = state;
      load_req   = 1'b0;
      shift_rx   = 1'b0;
      shift_tx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_assert) begin
               state_next = ST_ACTIVE;
               load_req   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cs_deassert) begin
               state_next = ST_IDLE;
            end else begin
               if (sclk_rise) begin
                  shift_rx = 1'b1;
               end
               if (sclk_fall) begin
                  if (word_done) begin
                     load_req = 1'b1;
                  end else begin
                     shift_tx = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Shift registers, bit counter and word-completion bookkeeping;
   // a completed word is published one cycle after its last bit lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         word_done   <= 1'b0;
         rx_pending  <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;

         if (rx_pending) begin
            rx_data    <= rx_shift;
            rx_valid   <= 1'b1;
            rx_pending <= 1'b0;
         end

         if (load_req) begin
            tx_shift    <= load_word;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            tx_underrun <= ~buf_full & ~tx_write;
         end else if (shift_tx) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
         end

         if (shift_rx) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_level};
            if (bit_cnt == LAST_BIT) begin
               bit_cnt    <= '0;
               word_done  <= 1'b1;
               rx_pending <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   // One-word transmit buffer: filled by an accepted write, emptied by a
   // word load. A write coinciding with a load bypasses the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else begin
         if (tx_write && !load_req) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
         end else if (load_req && buf_full) begin
            buf_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural mode-0 master running
// sclk at clk/8, with hand-computed expected words and strobe counts.
module tb_spi_slave_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       chip_select;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int rx_cnt   = 0;
   int ur_cnt   = 0;
   logic [7:0] rx_log [0:31];

   always #5 clk = ~clk;

   spi_slave_sync #(
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2),
      .DEFAULT_TX  (8'hA5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .chip_select (chip_select),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun),
      .busy        (busy)
   );

   // Count strobe cycles and log every received word, sampled mid-cycle
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_log[rx_cnt[4:0]] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
      if (tx_underrun === 1'b1) begin
         ur_cnt <= ur_cnt + 1;
      end
   end

   // Absolute time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic write_tx(input string tag, input logic [7:0] d);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      check_bit(tag, tx_ready, 1'b1);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic cs_start();
      chip_select = 1'b0;
      tick(6);
   endtask

   // Mode-0 master: mosi changes with the falling edge, miso is sampled
   // just before the rising edge; optionally release CS with the last fall.
   task automatic xfer(input logic [7:0] w, input int nbits, input bit end_cs,
                       output logic [7:0] m);
      m = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[7-i];
         tick(4);
         m[7-i] = miso;
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
         if (i == nbits - 1 && end_cs) begin
            chip_select = 1'b1;
         end
      end
      if (end_cs) begin
         tick(8);
      end
   endtask

   initial begin
      logic [7:0] m;
      logic [7:0] m2;
      int r0;
      int u0;

      reset       = 1'b1;
      chip_select = 1'b1;
      sclk        = 1'b0;
      mosi        = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      tick(3);
      check_bit("rst_miso", miso, 1'b0);
      check_bit("rst_miso_oe", miso_oe, 1'b0);
      check_bit("rst_tx_ready", tx_ready, 1'b1);
      check_byte("rst_rx_data", rx_data, 8'h00);
      check_bit("rst_rx_valid", rx_valid, 1'b0);
      check_bit("rst_underrun", tx_underrun, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick(3);

      $display("[TB] buffered word 3C, master sends C3");
      r0 = rx_cnt;
      u0 = ur_cnt;
      write_tx("t2_ready", 8'h3C);
      check_bit("t2_ready_low", tx_ready, 1'b0);
      cs_start();
      check_bit("t2_busy", busy, 1'b1);
      check_bit("t2_oe", miso_oe, 1'b1);
      check_bit("t2_ready_back", tx_ready, 1'b1);
      xfer(8'hC3, 8, 1'b1, m);
      tick(4);
      check_byte("t2_miso_word", m, 8'h3C);
      check_int("t2_rx_pulses", rx_cnt - r0, 1);
      check_byte("t2_rx_data", rx_data, 8'hC3);
      check_int("t2_underruns", ur_cnt - u0, 0);
      check_bit("t2_idle_busy", busy, 1'b0);
      check_bit("t2_idle_oe", miso_oe, 1'b0);

      $display("[TB] reset in the middle of a transfer");
      r0 = rx_cnt;
      cs_start();
      write_tx("t1_ready", 8'h77);
      xfer(8'hAA, 3, 1'b0, m);
      reset       = 1'b1;
      chip_select = 1'b1;
      tick(3);
      check_bit("t1_busy", busy, 1'b0);
      check_bit("t1_oe", miso_oe, 1'b0);
      check_bit("t1_miso", miso, 1'b0);
      check_bit("t1_tx_ready", tx_ready, 1'b1);
      check_byte("t1_rx_data", rx_data, 8'h00);
      check_bit("t1_underrun", tx_underrun, 1'b0);
      reset = 1'b0;
      tick(10);
      check_int("t1_rx_pulses", rx_cnt - r0, 0);
      check_bit("t1_busy_after", busy, 1'b0);

      $display("[TB] empty buffer, master sends 5A");
      r0 = rx_cnt;
      u0 = ur_cnt;
      cs_start();
      xfer(8'h5A, 8, 1'b1, m);
      tick(4);
      check_byte("t3_miso_word", m, 8'hA5);
      check_int("t3_underruns", ur_cnt - u0, 1);
      check_int("t3_rx_pulses", rx_cnt - r0, 1);
      check_byte("t3_rx_data", rx_data, 8'h5A);

      $display("[TB] two-word burst under one chip select");
      r0 = rx_cnt;
      u0 = ur_cnt;
      write_tx("t4_ready_a", 8'h11);
      cs_start();
      write_tx("t4_ready_b", 8'h22);
      check_bit("t4_ready_low", tx_ready, 1'b0);
      xfer(8'hF0, 8, 1'b0, m);
      xfer(8'h0F, 8, 1'b1, m2);
      tick(4);
      check_byte("t4_miso_w0", m, 8'h11);
      check_byte("t4_miso_w1", m2, 8'h22);
      check_int("t4_rx_pulses", rx_cnt - r0, 2);
      check_byte("t4_rx_w0", rx_log[r0[4:0]], 8'hF0);
      check_byte("t4_rx_w1", rx_log[5'(r0 + 1)], 8'h0F);
      check_int("t4_underruns", ur_cnt - u0, 0);
      check_bit("t4_tx_ready", tx_ready, 1'b1);

      $display("[TB] partial word then full word 81");
      r0 = rx_cnt;
      u0 = ur_cnt;
      cs_start();
      xfer(8'hFF, 5, 1'b1, m);
      tick(4);
      check_int("t5_partial_rx", rx_cnt - r0, 0);
      check_bit("t5_partial_busy", busy, 1'b0);
      cs_start();
      xfer(8'h81, 8, 1'b1, m);
      tick(4);
      check_int("t5_rx_pulses", rx_cnt - r0, 1);
      check_byte("t5_rx_data", rx_data, 8'h81);
      check_byte("t5_miso_word", m, 8'hA5);
      check_int("t5_underruns", ur_cnt - u0, 2);

      $display("[TB] tx_valid held with buffer full");
      u0 = ur_cnt;
      tx_data  = 8'h96;
      tx_valid = 1'b1;
      tick(1);
      check_bit("t6_ready_low0", tx_ready, 1'b0);
      tx_data = 8'h69;
      tick(4);
      check_bit("t6_ready_low1", tx_ready, 1'b0);
      tx_valid = 1'b0;
      cs_start();
      check_bit("t6_ready_after_load", tx_ready, 1'b1);
      xfer(8'h00, 8, 1'b1, m);
      check_byte("t6_miso_word", m, 8'h96);
      check_int("t6_underruns", ur_cnt - u0, 0);

      $display("[TB] chip select release together with sclk rise");
      r0 = rx_cnt;
      cs_start();
      xfer(8'hE7, 3, 1'b0, m);
      mosi = 1'b1;
      tick(4);
      sclk        = 1'b1;
      chip_select = 1'b1;
      tick(8);
      sclk = 1'b0;
      tick(8);
      check_bit("t6_cs_busy", busy, 1'b0);
      check_bit("t6_cs_oe", miso_oe, 1'b0);
      check_int("t6_cs_rx", rx_cnt - r0, 0);
      cs_start();
      xfer(8'h42, 8, 1'b1, m);
      tick(4);
      check_int("t6_next_rx_pulses", rx_cnt - r0, 1);
      check_byte("t6_next_rx_data", rx_data, 8'h42);
      check_byte("t6_next_miso", m, 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
